// File: rtl/fpu_operand_skid_stage.sv
// fpu_operand_skid_stage
// Registered hand-off between the operand-select multiplexer and the FPU
// execute stage. A two-entry skid buffer (main + skid register) keeps
// in_ready driven straight from a flop while sustaining one operand per
// cycle. The select tag travels with its data, and a saturating counter
// records the cycles the execute stage back-pressures a valid operand.

`ifndef DSIZE
`define DSIZE 32
`endif

module fpu_operand_skid_stage #(
  parameter int unsigned DSIZE = `DSIZE,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [DSIZE-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [DSIZE-1:0] out_data,
  output logic             out_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] stall_cnt
);

  // Occupancy encoded as {skid valid, main valid}; bit 0 is out_valid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_t;

  state_t             state_r;
  state_t             state_s;

  logic [DSIZE-1:0]   m_data_r;
  logic               m_sel_r;
  logic [DSIZE-1:0]   s_data_r;
  logic               s_sel_r;
  logic               in_ready_r;
  logic [CNT_W-1:0]   stall_cnt_r;

  logic               m_valid_s;
  logic               accept_s;
  logic               deliver_s;
  logic               stall_s;
  logic               m_load_s;
  logic               m_from_skid_s;
  logic               s_load_s;

  // Handshake qualifiers; in_ready comes from its own flop, so accept never
  // depends combinationally on out_ready.
  assign m_valid_s = state_r[0];
  assign accept_s  = in_valid & in_ready_r;
  assign deliver_s = m_valid_s & out_ready;
  assign stall_s   = m_valid_s & ~out_ready;

  // Next occupancy and register-load strobes; flush overrides any transfer.
  always_comb begin
    state_s       = state_r;
    m_load_s      = 1'b0;
    m_from_skid_s = 1'b0;
    s_load_s      = 1'b0;
    if (flush) begin
      state_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_s  = ST_ONE;
            m_load_s = 1'b1;
          end else begin
            state_s  = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && deliver_s) begin
            state_s  = ST_ONE;
            m_load_s = 1'b1;
          end else if (accept_s) begin
            state_s  = ST_FULL;
            s_load_s = 1'b1;
          end else if (deliver_s) begin
            state_s  = ST_EMPTY;
          end else begin
            state_s  = ST_ONE;
          end
        end
        ST_FULL: begin
          if (deliver_s) begin
            state_s       = ST_ONE;
            m_from_skid_s = 1'b1;
          end else begin
            state_s       = ST_FULL;
          end
        end
        default: begin
          state_s = ST_EMPTY;
        end
      endcase
    end
  end

  // Occupancy register and the flopped in_ready (ready whenever skid will be empty).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_EMPTY;
      in_ready_r <= 1'b1;
    end else begin
      state_r    <= state_s;
      in_ready_r <= ~state_s[1];
    end
  end

  // Main register: loads a fresh operand or the skid contents, otherwise holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_data_r <= {DSIZE{1'b0}};
      m_sel_r  <= 1'b0;
    end else if (m_load_s) begin
      m_data_r <= in_data;
      m_sel_r  <= in_sel;
    end else if (m_from_skid_s) begin
      m_data_r <= s_data_r;
      m_sel_r  <= s_sel_r;
    end else begin
      m_data_r <= m_data_r;
      m_sel_r  <= m_sel_r;
    end
  end

  // Skid register: only captures when the main register is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_data_r <= {DSIZE{1'b0}};
      s_sel_r  <= 1'b0;
    end else if (s_load_s) begin
      s_data_r <= in_data;
      s_sel_r  <= in_sel;
    end else begin
      s_data_r <= s_data_r;
      s_sel_r  <= s_sel_r;
    end
  end

  // Back-pressure counter; saturates at all-ones and survives flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = m_valid_s;
  assign out_data  = m_data_r;
  assign out_sel   = m_sel_r;
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_fpu_operand_skid_stage.sv
// Bench for fpu_operand_skid_stage: directed scenarios plus random traffic,
// checked every cycle against a queue-based FIFO model of the stage.
module tb_fpu_operand_skid_stage;

  localparam int DW    = 32;
  localparam int CW    = 4;
  localparam int SATV  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_sel = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_sel;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  fpu_operand_skid_stage #(.DSIZE(DW), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .stall_cnt (stall_cnt)
  );

  // Model: the stage is a 2-deep FIFO of {sel, data} plus a saturating count.
  logic [DW:0] q[$];
  int          mcnt = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare after it.
  task automatic step(input logic iv, input logic [DW-1:0] d, input logic s,
                      input logic ordy, input logic fl, input logic rs);
    bit dl;
    bit ac;
    in_valid  = iv;
    in_data   = d;
    in_sel    = s;
    out_ready = ordy;
    flush     = fl;
    reset     = rs;
    @(posedge clk);
    if (rs) begin
      q.delete();
      mcnt = 0;
    end else begin
      if (q.size() > 0 && !ordy && mcnt < SATV) mcnt++;
      if (fl) begin
        q.delete();
      end else begin
        dl = (q.size() > 0) && ordy;
        ac = iv && (q.size() < 2);
        if (dl) void'(q.pop_front());
        if (ac) q.push_back({s, d});
      end
    end
    #1;
    chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
    chk("in_ready",  {63'd0, in_ready},  {63'd0, q.size() < 2});
    chk("stall_cnt", {60'd0, stall_cnt}, mcnt);
    if (q.size() > 0) chk("out_tag_data", {31'd0, out_sel, out_data}, {31'd0, q[0]});
  endtask

  initial begin
    // reset state
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data",  {32'd0, out_data},  64'd0);
    chk("rst_out_sel",   {63'd0, out_sel},   64'd0);
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("rst_stall",     {60'd0, stall_cnt}, 64'd0);

    // single operand
    step(1'b1, 32'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t1_data",  {32'd0, out_data},  64'd1);
    chk("t1_sel",   {63'd0, out_sel},   64'd1);
    chk("t1_valid", {63'd0, out_valid}, 64'd1);
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t1_valid_after", {63'd0, out_valid}, 64'd0);

    // back-to-back stream at full rate
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, DW'(i), 1'b0, 1'b1, 1'b0, 1'b0);
      chk("t2_data",     {32'd0, out_data}, 64'(i));
      chk("t2_in_ready", {63'd0, in_ready}, 64'd1);
    end
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    // back-pressure fills the skid, then drains in order
    step(1'b1, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t3_in_ready_full", {63'd0, in_ready}, 64'd0);
    chk("t3_hold5",         {32'd0, out_data}, 64'd5);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_hold5_again",   {32'd0, out_data}, 64'd5);
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t3_then6",         {32'd0, out_data}, 64'd6);
    chk("t3_then6_sel",     {63'd0, out_sel},  64'd1);
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t3_stall",         {60'd0, stall_cnt}, 64'd3);
    chk("t3_drained",       {63'd0, out_valid}, 64'd0);

    // saturation at 15
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_saturate", {60'd0, stall_cnt}, 64'd15);
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_no_wrap",  {60'd0, stall_cnt}, 64'd15);

    // flush while full, with a concurrent accept attempt
    step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'd9, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t5_valid",    {63'd0, out_valid}, 64'd0);
    chk("t5_in_ready", {63'd0, in_ready},  64'd1);
    chk("t5_stall_kept", {60'd0, stall_cnt}, 64'd2);
    step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t5_nothing",  {63'd0, out_valid}, 64'd0);

    // reset while full
    step(1'b1, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("t6_valid",    {63'd0, out_valid}, 64'd0);
    chk("t6_data",     {32'd0, out_data},  64'd0);
    chk("t6_sel",      {63'd0, out_sel},   64'd0);
    chk("t6_in_ready", {63'd0, in_ready},  64'd1);
    chk("t6_stall",    {60'd0, stall_cnt}, 64'd0);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0,
           $urandom_range(0, 255) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
